input_pack_mem: RTL



---
 rtl/input_pack_mem.sv | 131 +++++++++++++
 1 files changed

// File: rtl/input_pack_mem.sv
// input_pack_mem
// Packs a byte-per-cycle pixel stream into 128-bit words and writes them to
// frame memory at sequential word addresses, with a buffer-select bit on top
// of the address. Raises done once a whole frame of words has been written.
module input_pack_mem #(
  parameter int WORDS_PER_FRAME = 19200,
  parameter int ADDR_W          = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              input_base_offset,
  input  logic [7:0]        DataIn,
  input  logic              DataValid,
  output logic [ADDR_W:0]   WriteAddress,
  output logic [127:0]      WriteBus,
  output logic              WriteEnable,
  output logic              done
);

  // A frame must fit in the word-index field and hold at least one word.
  generate
    if ((WORDS_PER_FRAME < 1) || (WORDS_PER_FRAME > (1 << ADDR_W))) begin : g_bad_cfg
      $error("input_pack_mem: WORDS_PER_FRAME must be in 1..2**ADDR_W");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_reg;
  logic              base_offset_reg;
  logic [3:0]        byte_count_reg;
  logic [ADDR_W-1:0] word_index_reg;

  // Bytes 0..14 of the word being assembled. The 16th byte never needs a
  // lane of its own: it is merged straight into WriteBus on the write edge,
  // which is what lets the lanes be reused on the very next cycle.
  logic [119:0]      assembly;
  logic              byte_accept;
  logic              word_complete;

  assign byte_accept   = (state_reg == ACTIVE) && DataValid;
  assign word_complete = byte_accept && (byte_count_reg == 4'd15);

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_lane
      logic [7:0] lane_reg;

      // Capture the incoming byte when the byte counter points at this lane.
      always_ff @(posedge clock) begin
        if (reset) begin
          lane_reg <= 8'd0;
        end else if (byte_accept && (byte_count_reg == 4'(gi))) begin
          lane_reg <= DataIn;
        end
      end

      assign assembly[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // Frame control FSM with registered write strobe, address, bus and done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      base_offset_reg <= 1'b0;
      byte_count_reg  <= 4'd0;
      word_index_reg  <= '0;
      WriteAddress    <= '0;
      WriteBus        <= '0;
      WriteEnable     <= 1'b0;
      done            <= 1'b0;
    end else begin
      WriteEnable <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_offset_reg <= input_base_offset;
            byte_count_reg  <= 4'd0;
            word_index_reg  <= '0;
            state_reg       <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (byte_accept) begin
            byte_count_reg <= byte_count_reg + 4'd1;
          end
          if (word_complete) begin
            // A word finishing in the same cycle start falls is still written.
            WriteBus     <= {DataIn, assembly};
            WriteAddress <= {base_offset_reg, word_index_reg};
            WriteEnable  <= 1'b1;
            if (word_index_reg == LAST_IDX) begin
              state_reg <= DONE;
            end else begin
              word_index_reg <= word_index_reg + 1'b1;
              if (!start) begin
                state_reg <= IDLE;
              end
            end
          end else if (!start) begin
            // Abort: any partial word is simply abandoned.
            state_reg <= IDLE;
          end
        end

        DONE: begin
          if (start) begin
            done <= 1'b1;
          end else begin
            done      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
